// File: rtl/regfile_phased.sv
// Multi-read-port register file that accepts one write per phase cycle
// and initialises itself with a sequential sweep after reset.
module regfile_phased #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 5,
   parameter int unsigned NUM_READ    = 2,
   parameter int unsigned PHASES      = 10,
   parameter int unsigned WRITE_PHASE = 3,
   parameter int unsigned ZERO_REG    = 1,
   parameter int unsigned INIT_MODE   = 0,
   parameter int unsigned BYPASS      = 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           regWrite,
   input  logic [ADDR_WIDTH-1:0]          writeReg,
   input  logic [DATA_WIDTH-1:0]          writeData,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] readReg,
   output logic [NUM_READ*DATA_WIDTH-1:0] readData,
   output logic                           busy,
   output logic [3:0]                     phase,
   output logic                           writeAck
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {
      SWEEP = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [ADDR_WIDTH-1:0] w_idx_next;
   logic [3:0]            r_phase;
   logic [3:0]            w_phase_next;
   logic                  r_ack;
   logic                  w_accept;
   logic                  w_keep;
   logic                  w_sweep_we;
   logic [DATA_WIDTH-1:0] r_regs [DEPTH];

   // State register and registered control outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= SWEEP;
         r_idx   <= '0;
         r_phase <= 4'd0;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         r_phase <= w_phase_next;
         r_ack   <= w_accept;
      end
   end

   // Next state: leave the sweep after the last index has been written
   always_comb begin
      w_state_next = r_state;
      if (r_state == SWEEP && r_idx == ADDR_WIDTH'(DEPTH - 1)) begin
         w_state_next = READY;
      end
   end

   // Per-state control: sweep addressing, phase counting, write acceptance
   always_comb begin
      w_idx_next   = r_idx;
      w_phase_next = r_phase;
      w_accept     = 1'b0;
      w_sweep_we   = 1'b0;
      if (r_state == SWEEP) begin
         w_sweep_we   = 1'b1;
         w_idx_next   = r_idx + ADDR_WIDTH'(1);
         w_phase_next = 4'd0;
      end else begin
         w_phase_next = (r_phase == 4'(PHASES - 1)) ? 4'd0 : r_phase + 4'd1;
         w_accept     = regWrite && (r_phase == 4'(WRITE_PHASE));
      end
   end

   // Accepted writes to the hardwired zero register are acknowledged but dropped
   assign w_keep = w_accept && !((ZERO_REG != 0) && (writeReg == '0));

   always_ff @(posedge clock) begin
      if (w_sweep_we) begin
         r_regs[r_idx] <= (INIT_MODE == 1) ? DATA_WIDTH'(r_idx) : '0;
      end else if (w_keep) begin
         r_regs[writeReg] <= writeData;
      end
   end

   for (genvar k = 0; k < int'(NUM_READ); k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_raddr;
      logic [DATA_WIDTH-1:0] w_rdata;

      assign w_raddr = readReg[k*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         w_rdata = r_regs[w_raddr];
         if ((BYPASS != 0) && w_keep && (w_raddr == writeReg)) begin
            w_rdata = writeData;
         end
         if ((r_state == SWEEP) || ((ZERO_REG != 0) && (w_raddr == '0))) begin
            w_rdata = '0;
         end
      end

      assign readData[k*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
   end

   assign busy     = (r_state == SWEEP);
   assign phase    = r_phase;
   assign writeAck = r_ack;

endmodule

// File: tb/tb_regfile_phased.sv
// Bench for regfile_phased: bypassing and non-bypassing instances driven in
// lockstep, checked against an array model with a cycle-count phase.
module tb_regfile_phased;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NR    = 2;
   localparam int unsigned PH    = 10;
   localparam int unsigned WP    = 3;
   localparam int unsigned DEPTH = 32;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic                 regWrite = 1'b0;
   logic [AW-1:0]        writeReg = '0;
   logic [DW-1:0]        writeData = '0;
   logic [NR*AW-1:0]     readReg = '0;
   logic [NR*DW-1:0]     rd_b, rd_n;
   logic                 busy_b, busy_n, ack_b, ack_n;
   logic [3:0]           ph_b, ph_n;

   always #5 clock = ~clock;

   regfile_phased #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .PHASES(PH),
      .WRITE_PHASE(WP), .ZERO_REG(1), .INIT_MODE(1), .BYPASS(1)
   ) dut_b (
      .clock(clock), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
      .writeData(writeData), .readReg(readReg), .readData(rd_b),
      .busy(busy_b), .phase(ph_b), .writeAck(ack_b)
   );

   regfile_phased #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .PHASES(PH),
      .WRITE_PHASE(WP), .ZERO_REG(1), .INIT_MODE(1), .BYPASS(0)
   ) dut_n (
      .clock(clock), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
      .writeData(writeData), .readReg(readReg), .readData(rd_n),
      .busy(busy_n), .phase(ph_n), .writeAck(ack_n)
   );

   // Reference model: sweep progress, cycles spent in READY, register array
   bit          m_sweep = 1'b1;
   int          m_idx = 0;
   int          m_ready_cyc = 0;
   bit          m_ack = 1'b0;
   logic [31:0] m_mem [DEPTH];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic bit m_accept();
      return !m_sweep && reset && regWrite && ((m_ready_cyc % PH) == WP);
   endfunction

   function automatic logic [31:0] m_read(input logic [AW-1:0] a, input bit byp);
      if (m_sweep || a == 0) return 32'h0;
      if (byp && m_accept() && writeReg != 0 && a == writeReg) return writeData;
      return m_mem[a];
   endfunction

   function automatic logic [NR*AW-1:0] rr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      return {a1, a0};
   endfunction

   task automatic check_outputs();
      logic [AW-1:0] a;
      check_val("busy_byp", 32'(busy_b), 32'(m_sweep));
      check_val("busy_nob", 32'(busy_n), 32'(m_sweep));
      check_val("phase", 32'(ph_b), m_sweep ? 32'd0 : 32'(m_ready_cyc % PH));
      check_val("ack_byp", 32'(ack_b), 32'(m_ack));
      check_val("ack_nob", 32'(ack_n), 32'(m_ack));
      for (int k = 0; k < NR; k++) begin
         a = readReg[k*AW +: AW];
         check_val($sformatf("rd_byp%0d", k), rd_b[k*DW +: DW], m_read(a, 1'b1));
         check_val($sformatf("rd_nob%0d", k), rd_n[k*DW +: DW], m_read(a, 1'b0));
      end
   endtask

   task automatic m_reset();
      m_sweep = 1'b1;
      m_idx = 0;
      m_ack = 1'b0;
      m_ready_cyc = 0;
   endtask

   // One clock: drive on the falling edge, check, then advance model on the rising edge
   task automatic cycle(input bit rw, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                        input logic [NR*AW-1:0] r);
      bit acc;
      @(negedge clock);
      regWrite = rw; writeReg = wr; writeData = wd; readReg = r;
      #1;
      check_outputs();
      @(posedge clock);
      if (!reset) return;
      if (m_sweep) begin
         m_mem[m_idx] = 32'(m_idx);
         m_idx++;
         m_ack = 1'b0;
         if (m_idx == DEPTH) begin
            m_sweep = 1'b0;
            m_ready_cyc = 0;
         end
      end else begin
         acc = m_accept();
         if (acc && wr != 0) m_mem[wr] = wd;
         m_ack = acc;
         m_ready_cyc++;
      end
   endtask

   task automatic rand_cycle(input bit rw);
      cycle(rw, AW'($urandom), $urandom, rr(AW'($urandom), AW'($urandom)));
   endtask

   task automatic apply_reset(input int cycles_low);
      @(negedge clock);
      reset = 1'b0;
      #1;
      m_reset();
      check_outputs();
      repeat (cycles_low) rand_cycle(1'b1);
      #2 reset = 1'b1;
   endtask

   initial begin
      m_reset();
      apply_reset(2);

      // Sweep with INIT_MODE=1, then reads of 5 / 31 / 0
      repeat (34) cycle(1'b0, '0, '0, rr(5'd5, 5'd31));
      repeat (3) cycle(1'b0, '0, '0, rr(5'd0, 5'd5));

      // Held write to reg 7: accepted only at the write phase
      repeat (25) cycle(1'b1, 5'd7, 32'hDEADBEEF, rr(5'd7, 5'd3));

      // Request only at phase 4 is dropped
      for (int i = 0; i < 20; i++)
         cycle((m_ready_cyc % PH) == 4, 5'd8, $urandom, rr(5'd8, 5'd7));

      // Bypass on both ports
      repeat (12) cycle(1'b1, 5'd9, 32'h12345678, rr(5'd9, 5'd9));

      // Zero register ignores writes, including the bypass cycle
      repeat (12) cycle(1'b1, 5'd0, 32'hFFFFFFFF, rr(5'd0, 5'd0));

      // Reset mid-sweep restarts the sweep
      apply_reset(1);
      repeat (10) rand_cycle(1'b1);
      apply_reset(1);
      repeat (40) rand_cycle(1'b1);

      // Random traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 249) == 0) apply_reset(1);
         rand_cycle($urandom_range(0, 1) == 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_phased.md
# regfile_phased

Parametrised multi-read-port register file for the multicycle datapath. It holds `2**ADDR_WIDTH` registers of `DATA_WIDTH` bits and accepts one write per datapath cycle, at a programmable phase of an internal phase counter. After reset it initialises its own contents with a sequential sweep, then serves any number of combinational read ports with optional write-through bypass. It sits between the control unit (`regWrite`) and the ALU operand muxes.

## Interface
- `DATA_WIDTH`, 32, register width in bits
- `ADDR_WIDTH`, 5, register address width; depth = `2**ADDR_WIDTH`
- `NUM_READ`, 2, number of read ports (1..4)
- `PHASES`, 10, length of the phase counter cycle (2..16)
- `WRITE_PHASE`, 3, phase value at which a write is accepted (0..PHASES-1)
- `ZERO_REG`, 1, 1 = register 0 always reads 0 and ignores writes
- `INIT_MODE`, 0, initialisation value: 0 = all zero; 1 = register i holds i (zero-extended)
- `BYPASS`, 1, 1 = a read of the register being written returns `writeData` in the same cycle
- `clock` input 1, single clock; all state updates on its rising edge
- `reset` input 1, asynchronous, active-low; 0 = reset asserted
- `regWrite` input 1, write request
- `writeReg` input ADDR_WIDTH, write address
- `writeData` input DATA_WIDTH, write data
- `readReg` input NUM_READ*ADDR_WIDTH, packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- `readData` output NUM_READ*DATA_WIDTH, packed read data, packed the same way
- `busy` output 1, high during reset and during the init sweep
- `phase` output 4, current phase counter value
- `writeAck` output 1, registered one-cycle pulse on the cycle after a write is accepted

## Operation
- States: SWEEP and READY.
- While `reset`=0: state=SWEEP, sweep index=0, `phase`=0, `writeAck`=0, `busy`=1, `readData`=0. The array is not cleared asynchronously.
- SWEEP:
  - Each clock writes the INIT_MODE value to `regs[index]`, then increments the index.
  - After writing index `2**ADDR_WIDTH-1`, moves to READY.
  - Sweep duration is `2**ADDR_WIDTH` cycles.
  - `phase` holds 0; `regWrite` is ignored; `readData` is forced to 0.
- READY:
  - `phase` increments every clock and wraps from PHASES-1 to 0.
  - A write is accepted when `regWrite`=1 and the current registered `phase`==WRITE_PHASE. At that edge `regs[writeReg]<=writeData`.
  - `writeAck` is 1 in the following cycle only.
- ZERO_REG=1:
  - A write to address 0 is accepted (`writeAck` pulses) but discarded.
  - Every read of address 0 returns 0, including during bypass.
- Read port k returns `regs[readReg[k]]` combinationally. If BYPASS=1, a write is being accepted this cycle, and `readReg[k]`==`writeReg` (not discarded), the port returns `writeData` instead.
- All read ports are independent; identical addresses on multiple ports are legal.
- `busy`=1 exactly in SWEEP.

## Timing
- Reset assertion takes effect immediately (asynchronous). Deassertion is synchronised by the first rising edge: the sweep writes index 0 on the first edge with `reset`=1.
- `busy` falls on the edge that writes the last index. `phase`=0 in the first READY cycle.
- The first write opportunity is WRITE_PHASE cycles after `busy` falls. After that, one opportunity occurs every PHASES cycles.
- Write latency:
  - Data is visible on non-bypassed reads the cycle after acceptance.
  - With BYPASS=1, data is visible in the same cycle.
- `regWrite` outside WRITE_PHASE is dropped without a pulse; there is no queuing.
- Reset mid-sweep or mid-operation restarts the sweep from index 0. Partially written contents are overwritten by the sweep.
- Width rules:
  - INIT_MODE=1 values are truncated to DATA_WIDTH when ADDR_WIDTH > DATA_WIDTH.
  - `phase` is zero-extended to 4 bits.

## Test plan
- Reset then sweep, INIT_MODE=1, defaults:
  - Pulse `reset`=0 → `busy`=1, `readData`=0.
  - Release → `busy` falls after 32 clocks.
  - Reads of reg 5 and reg 31 return 5 and 31; reg 0 returns 0.
- Phased write:
  - In READY, hold `regWrite`=1, `writeReg`=7, `writeData`=32'hDEADBEEF.
  - Write is accepted only at `phase`=3.
  - `writeAck` pulses once per 10 cycles.
  - With BYPASS=0, reg 7 reads DEADBEEF from the next cycle.
- Dropped write: `regWrite`=1 only at `phase`=4 → no `writeAck`, reg contents unchanged.
- Bypass: BYPASS=1, both read ports at reg 9, write 32'h12345678 to reg 9 at `phase`=3 → both ports show 12345678 in the same cycle.
- Zero register: write 32'hFFFFFFFF to reg 0 → `writeAck`=1, reg 0 still reads 0, including the bypass cycle.
- Reset mid-sweep: assert `reset` at sweep index 10 → sweep restarts at 0; full 32-cycle `busy` follows release; contents are re-initialised.
